// File: rtl/gobou_ctrl_mac_pipe_pkg.sv
// Shared types and defaults for the gobou MAC pipeline controller.
package gobou_ctrl_mac_pipe_pkg;

   localparam int unsigned MACLAT_DEFAULT = 2;
   localparam int unsigned TILEWD_DEFAULT = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_EMIT  = 2'd3
   } mac_state_t;

   // One accepted control beat as it travels down the MAC latency line
   typedef struct packed {
      logic valid;
      logic stop;
      logic last;
   } ctrl_beat_t;

   localparam int unsigned CTRL_BEAT_W = $bits(ctrl_beat_t);

endpackage

// File: rtl/gobou_ctrl_mac_pipe_if.sv
// Stream control bus: start/valid/stop framing, one bit each.
interface gobou_ctrl_mac_pipe_if;

   logic start;
   logic valid;
   logic stop;

   modport master (output start, output valid, output stop);
   modport slave  (input  start, input  valid, input  stop);

endinterface

// File: rtl/gobou_ctrl_delay.sv
// Fixed-depth shift register with asynchronous active-low clear.
module gobou_ctrl_delay #(
   parameter int unsigned DEPTH = 1,
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             xrst,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_sr [DEPTH];

   always_ff @(posedge clk or negedge xrst) begin
      if (!xrst) begin
         for (int i = 0; i < int'(DEPTH); i++) r_sr[i] <= '0;
      end else begin
         r_sr[0] <= i_d;
         for (int i = 1; i < int'(DEPTH); i++) r_sr[i] <= r_sr[i-1];
      end
   end

   assign o_q = r_sr[DEPTH-1];

endmodule

// File: rtl/gobou_ctrl_mac_pipe.sv
// MAC pipeline controller: counts tiles per job, delays control by the MAC
// latency, and frames one accumulated result per job on out_ctrl.
module gobou_ctrl_mac_pipe
   import gobou_ctrl_mac_pipe_pkg::*;
#(
   parameter int unsigned MACLAT = MACLAT_DEFAULT,
   parameter int unsigned TILEWD = TILEWD_DEFAULT
) (
   input  logic                  clk,
   input  logic                  xrst,
   gobou_ctrl_mac_pipe_if.slave  in_ctrl,
   gobou_ctrl_mac_pipe_if.master out_ctrl,
   input  logic [TILEWD-1:0]     n_tile,
   output logic                  mac_oe,
   output logic                  accum_we,
   output logic                  accum_rst,
   output logic                  busy,
   output logic                  err
);

   mac_state_t        r_state;
   logic [TILEWD-1:0] r_n_eff;
   logic [TILEWD-1:0] r_tile_cnt;
   logic              r_emit;
   logic              r_err;

   logic              w_run;
   logic              w_last_cnt;
   ctrl_beat_t        w_beat_in;
   ctrl_beat_t        w_beat_dly;

   assign w_run      = (r_state == ST_RUN);
   assign w_last_cnt = (r_tile_cnt == (r_n_eff - TILEWD'(1)));

   // Only RUN-state beats enter the latency line
   always_comb begin
      w_beat_in       = '0;
      w_beat_in.valid = w_run & in_ctrl.valid;
      w_beat_in.stop  = w_run & in_ctrl.stop;
      w_beat_in.last  = w_run & in_ctrl.stop & w_last_cnt;
   end

   gobou_ctrl_delay #(
      .DEPTH (MACLAT),
      .WIDTH (CTRL_BEAT_W)
   ) u_delay (
      .clk  (clk),
      .xrst (xrst),
      .i_d  (w_beat_in),
      .o_q  (w_beat_dly)
   );

   always_ff @(posedge clk or negedge xrst) begin
      if (!xrst) begin
         r_state    <= ST_IDLE;
         r_n_eff    <= '0;
         r_tile_cnt <= '0;
         r_emit     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_emit <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (in_ctrl.start) begin
                  r_state    <= ST_RUN;
                  r_n_eff    <= (n_tile == '0) ? TILEWD'(1) : n_tile;
                  r_tile_cnt <= '0;
               end
            end
            ST_RUN: begin
               // start inside RUN is only a segment marker and is ignored
               if (in_ctrl.stop) begin
                  r_tile_cnt <= r_tile_cnt + TILEWD'(1);
                  if (w_last_cnt) r_state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (in_ctrl.start) r_err <= 1'b1;
               if (mac_oe) begin
                  r_state <= ST_EMIT;
                  r_emit  <= 1'b1;
               end
            end
            ST_EMIT: begin
               if (in_ctrl.start) r_err <= 1'b1;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign accum_we       = w_beat_dly.valid & ~w_beat_dly.stop;
   assign mac_oe         = w_beat_dly.stop & w_beat_dly.last;
   assign accum_rst      = r_emit;
   assign busy           = (r_state != ST_IDLE);
   assign err            = r_err;
   assign out_ctrl.start = mac_oe;
   assign out_ctrl.valid = r_emit;
   assign out_ctrl.stop  = r_emit;

endmodule

// File: tb/tb_gobou_ctrl_mac_pipe.sv
// Directed bench for gobou_ctrl_mac_pipe at MACLAT 2 (main), 1 and 8 (sweep).
module tb_gobou_ctrl_mac_pipe;

   logic       clk = 1'b0;
   logic       xrst = 1'b1;
   logic [7:0] n_tile = 8'd1;

   always #5 clk = ~clk;

   gobou_ctrl_mac_pipe_if in_if ();
   gobou_ctrl_mac_pipe_if out_if ();
   gobou_ctrl_mac_pipe_if in1_if ();
   gobou_ctrl_mac_pipe_if out1_if ();
   gobou_ctrl_mac_pipe_if in8_if ();
   gobou_ctrl_mac_pipe_if out8_if ();

   logic mac_oe, accum_we, accum_rst, busy, err;
   logic mac_oe1, accum_we1, accum_rst1, busy1, err1;
   logic mac_oe8, accum_we8, accum_rst8, busy8, err8;

   gobou_ctrl_mac_pipe #(.MACLAT(2), .TILEWD(8)) dut (
      .clk(clk), .xrst(xrst), .in_ctrl(in_if), .out_ctrl(out_if), .n_tile(n_tile),
      .mac_oe(mac_oe), .accum_we(accum_we), .accum_rst(accum_rst), .busy(busy), .err(err));

   gobou_ctrl_mac_pipe #(.MACLAT(1), .TILEWD(8)) dut1 (
      .clk(clk), .xrst(xrst), .in_ctrl(in1_if), .out_ctrl(out1_if), .n_tile(n_tile),
      .mac_oe(mac_oe1), .accum_we(accum_we1), .accum_rst(accum_rst1), .busy(busy1), .err(err1));

   gobou_ctrl_mac_pipe #(.MACLAT(8), .TILEWD(8)) dut8 (
      .clk(clk), .xrst(xrst), .in_ctrl(in8_if), .out_ctrl(out8_if), .n_tile(n_tile),
      .mac_oe(mac_oe8), .accum_we(accum_we8), .accum_rst(accum_rst8), .busy(busy8), .err(err8));

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   // Per-cycle traces; bit k holds the value seen in cycle k of the current job
   logic [31:0] v_we, v_oe, v_ar, v_os, v_ov, v_op, v_busy, v_err;
   logic [31:0] v1_we, v1_oe, v1_busy, v8_we, v8_oe, v8_busy;

   task automatic clear_log();
      v_we = '0; v_oe = '0; v_ar = '0; v_os = '0; v_ov = '0; v_op = '0;
      v_busy = '0; v_err = '0;
      v1_we = '0; v1_oe = '0; v1_busy = '0; v8_we = '0; v8_oe = '0; v8_busy = '0;
      cyc = 0;
   endtask

   // Drive one cycle (side=1 targets the MACLAT 1/8 pair), trace outputs mid-cycle
   task automatic drive(input logic s, input logic v, input logic p, input bit side);
      in_if.start  = side ? 1'b0 : s;
      in_if.valid  = side ? 1'b0 : v;
      in_if.stop   = side ? 1'b0 : p;
      in1_if.start = side ? s : 1'b0;
      in1_if.valid = side ? v : 1'b0;
      in1_if.stop  = side ? p : 1'b0;
      in8_if.start = side ? s : 1'b0;
      in8_if.valid = side ? v : 1'b0;
      in8_if.stop  = side ? p : 1'b0;
      @(negedge clk);
      if (cyc < 32) begin
         v_we[cyc[4:0]]    = accum_we;
         v_oe[cyc[4:0]]    = mac_oe;
         v_ar[cyc[4:0]]    = accum_rst;
         v_os[cyc[4:0]]    = out_if.start;
         v_ov[cyc[4:0]]    = out_if.valid;
         v_op[cyc[4:0]]    = out_if.stop;
         v_busy[cyc[4:0]]  = busy;
         v_err[cyc[4:0]]   = err;
         v1_we[cyc[4:0]]   = accum_we1;
         v1_oe[cyc[4:0]]   = mac_oe1;
         v1_busy[cyc[4:0]] = busy1;
         v8_we[cyc[4:0]]   = accum_we8;
         v8_oe[cyc[4:0]]   = mac_oe8;
         v8_busy[cyc[4:0]] = busy8;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic test_reset();
      in_if.start = 1'b0; in_if.valid = 1'b0; in_if.stop = 1'b0;
      in1_if.start = 1'b0; in1_if.valid = 1'b0; in1_if.stop = 1'b0;
      in8_if.start = 1'b0; in8_if.valid = 1'b0; in8_if.stop = 1'b0;
      @(posedge clk);
      #2 xrst = 1'b0;
      #1;
      if ({mac_oe, accum_we, accum_rst, busy, err, out_if.start, out_if.valid, out_if.stop} !== 8'h00) begin
         errors++;
         $display("FAIL reset_main outputs got=%b exp=00000000",
                  {mac_oe, accum_we, accum_rst, busy, err, out_if.start, out_if.valid, out_if.stop});
      end
      checks++;
      if ({mac_oe1, accum_we1, busy1, err1, mac_oe8, accum_we8, busy8, err8} !== 8'h00) begin
         errors++;
         $display("FAIL reset_side outputs got=%b exp=00000000",
                  {mac_oe1, accum_we1, busy1, err1, mac_oe8, accum_we8, busy8, err8});
      end
      checks++;
      repeat (2) @(posedge clk);
      @(negedge clk) xrst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // One-tile job: start@0, valid@1..4, stop@5
   task automatic test_single(input logic [7:0] nt, input logic err_exp, input string tag);
      logic [31:0] exp_err;
      exp_err = err_exp ? 32'h0000_0FFF : 32'h0;
      n_tile = nt;
      clear_log();
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      repeat (4) drive(1'b0, 1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      repeat (6) drive(1'b0, 1'b0, 1'b0, 1'b0);
      if (v_we !== 32'h0000_0078) begin errors++; $display("FAIL %s accum_we got=%h exp=%h", tag, v_we, 32'h78); end
      checks++;
      if (v_oe !== 32'h0000_0080) begin errors++; $display("FAIL %s mac_oe got=%h exp=%h", tag, v_oe, 32'h80); end
      checks++;
      if (v_os !== 32'h0000_0080) begin errors++; $display("FAIL %s out_start got=%h exp=%h", tag, v_os, 32'h80); end
      checks++;
      if (v_ar !== 32'h0000_0100) begin errors++; $display("FAIL %s accum_rst got=%h exp=%h", tag, v_ar, 32'h100); end
      checks++;
      if (v_ov !== 32'h0000_0100) begin errors++; $display("FAIL %s out_valid got=%h exp=%h", tag, v_ov, 32'h100); end
      checks++;
      if (v_op !== 32'h0000_0100) begin errors++; $display("FAIL %s out_stop got=%h exp=%h", tag, v_op, 32'h100); end
      checks++;
      if (v_busy !== 32'h0000_01FE) begin errors++; $display("FAIL %s busy got=%h exp=%h", tag, v_busy, 32'h1FE); end
      checks++;
      if (v_err !== exp_err) begin errors++; $display("FAIL %s err got=%h exp=%h", tag, v_err, exp_err); end
      checks++;
   endtask

   // Three tiles of two beats; the first stop also carries valid (must not write)
   task automatic test_multi_tile();
      n_tile = 8'd3;
      clear_log();
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      for (int t = 0; t < 3; t++) begin
         drive(1'b0, 1'b1, 1'b0, 1'b0);
         drive(1'b0, 1'b1, 1'b0, 1'b0);
         drive(1'b0, (t == 0), 1'b1, 1'b0);
      end
      repeat (6) drive(1'b0, 1'b0, 1'b0, 1'b0);
      if (v_we !== 32'h0000_06D8) begin errors++; $display("FAIL multi accum_we got=%h exp=%h", v_we, 32'h6D8); end
      checks++;
      if (v_oe !== 32'h0000_0800) begin errors++; $display("FAIL multi mac_oe got=%h exp=%h", v_oe, 32'h800); end
      checks++;
      if (v_os !== 32'h0000_0800) begin errors++; $display("FAIL multi out_start got=%h exp=%h", v_os, 32'h800); end
      checks++;
      if (v_ar !== 32'h0000_1000) begin errors++; $display("FAIL multi accum_rst got=%h exp=%h", v_ar, 32'h1000); end
      checks++;
      if ((v_ov | v_op) !== 32'h0000_1000) begin errors++; $display("FAIL multi out_valid_stop got=%h exp=%h", v_ov | v_op, 32'h1000); end
      checks++;
      if (v_busy !== 32'h0000_1FFE) begin errors++; $display("FAIL multi busy got=%h exp=%h", v_busy, 32'h1FFE); end
      checks++;
   endtask

   // start/stop in DRAIN and valid in the mac_oe cycle; then a normal job
   task automatic test_err_drain();
      n_tile = 8'd1;
      clear_log();
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 1'b1, 1'b0);
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      repeat (11) drive(1'b0, 1'b0, 1'b0, 1'b0);
      if (v_err !== 32'h0000_FFF0) begin errors++; $display("FAIL err_drain err got=%h exp=%h", v_err, 32'hFFF0); end
      checks++;
      if (v_we !== 32'h0000_0008) begin errors++; $display("FAIL err_drain accum_we got=%h exp=%h", v_we, 32'h8); end
      checks++;
      if (v_oe !== 32'h0000_0010) begin errors++; $display("FAIL err_drain mac_oe got=%h exp=%h", v_oe, 32'h10); end
      checks++;
      if (v_ar !== 32'h0000_0020) begin errors++; $display("FAIL err_drain accum_rst got=%h exp=%h", v_ar, 32'h20); end
      checks++;
      if (v_busy !== 32'h0000_003E) begin errors++; $display("FAIL err_drain busy got=%h exp=%h", v_busy, 32'h3E); end
      checks++;
      test_single(8'd1, 1'b1, "after_err");
   endtask

   // Reset mid-RUN of a 2-tile job, start held across release
   task automatic test_reset_mid();
      n_tile = 8'd2;
      clear_log();
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      in_if.valid = 1'b0;
      if (busy !== 1'b1) begin errors++; $display("FAIL rst_mid busy_before got=%b exp=1", busy); end
      checks++;
      #1 xrst = 1'b0;
      #1;
      if ({mac_oe, accum_we, accum_rst, busy, err, out_if.start, out_if.valid, out_if.stop} !== 8'h00) begin
         errors++;
         $display("FAIL rst_mid outputs got=%b exp=00000000",
                  {mac_oe, accum_we, accum_rst, busy, err, out_if.start, out_if.valid, out_if.stop});
      end
      checks++;
      n_tile = 8'd1;
      in_if.start = 1'b1;
      @(posedge clk);
      @(negedge clk) xrst = 1'b1;
      clear_log();
      @(posedge clk);
      #1;
      cyc = 1;
      repeat (4) drive(1'b0, 1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      repeat (6) drive(1'b0, 1'b0, 1'b0, 1'b0);
      if (v_we !== 32'h0000_0078) begin errors++; $display("FAIL rst_mid accum_we got=%h exp=%h", v_we, 32'h78); end
      checks++;
      if (v_oe !== 32'h0000_0080) begin errors++; $display("FAIL rst_mid mac_oe got=%h exp=%h", v_oe, 32'h80); end
      checks++;
      if (v_os !== 32'h0000_0080) begin errors++; $display("FAIL rst_mid out_start got=%h exp=%h", v_os, 32'h80); end
      checks++;
      if (v_ar !== 32'h0000_0100) begin errors++; $display("FAIL rst_mid accum_rst got=%h exp=%h", v_ar, 32'h100); end
      checks++;
      if (v_busy !== 32'h0000_01FE) begin errors++; $display("FAIL rst_mid busy got=%h exp=%h", v_busy, 32'h1FE); end
      checks++;
      if (v_err !== 32'h0) begin errors++; $display("FAIL rst_mid err got=%h exp=%h", v_err, 32'h0); end
      checks++;
   endtask

   // MACLAT 1 and 8: start@0, valid@1, stop@2
   task automatic test_maclat_sweep();
      n_tile = 8'd1;
      clear_log();
      drive(1'b1, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 1'b1, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b1, 1'b1);
      repeat (13) drive(1'b0, 1'b0, 1'b0, 1'b1);
      if (v1_we !== 32'h0000_0004) begin errors++; $display("FAIL lat1 accum_we got=%h exp=%h", v1_we, 32'h4); end
      checks++;
      if (v1_oe !== 32'h0000_0008) begin errors++; $display("FAIL lat1 mac_oe got=%h exp=%h", v1_oe, 32'h8); end
      checks++;
      if (v1_busy !== 32'h0000_001E) begin errors++; $display("FAIL lat1 busy got=%h exp=%h", v1_busy, 32'h1E); end
      checks++;
      if (v8_we !== 32'h0000_0200) begin errors++; $display("FAIL lat8 accum_we got=%h exp=%h", v8_we, 32'h200); end
      checks++;
      if (v8_oe !== 32'h0000_0400) begin errors++; $display("FAIL lat8 mac_oe got=%h exp=%h", v8_oe, 32'h400); end
      checks++;
      if (v8_busy !== 32'h0000_0FFE) begin errors++; $display("FAIL lat8 busy got=%h exp=%h", v8_busy, 32'hFFE); end
      checks++;
      if (v_busy !== 32'h0) begin errors++; $display("FAIL lat_sweep main_busy got=%h exp=%h", v_busy, 32'h0); end
      checks++;
   endtask

   // n_tile = 255: stops at cycles 1..255, so mac_oe@257 and accum_rst@258
   task automatic test_max_tiles();
      int oe_cnt, oe_cyc, ar_cnt, ar_cyc;
      oe_cnt = 0; oe_cyc = -1; ar_cnt = 0; ar_cyc = -1;
      n_tile = 8'd255;
      clear_log();
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      for (int k = 1; k < 267; k++) begin
         if (mac_oe) begin oe_cnt++; oe_cyc = cyc; end
         if (accum_rst) begin ar_cnt++; ar_cyc = cyc; end
         drive(1'b0, 1'b0, (k <= 255), 1'b0);
      end
      if (oe_cnt !== 1) begin errors++; $display("FAIL max_tiles oe_count got=%0d exp=1", oe_cnt); end
      checks++;
      if (oe_cyc !== 257) begin errors++; $display("FAIL max_tiles oe_cycle got=%0d exp=257", oe_cyc); end
      checks++;
      if (ar_cnt !== 1) begin errors++; $display("FAIL max_tiles rst_count got=%0d exp=1", ar_cnt); end
      checks++;
      if (ar_cyc !== 258) begin errors++; $display("FAIL max_tiles rst_cycle got=%0d exp=258", ar_cyc); end
      checks++;
   endtask

   initial begin
      test_reset();
      test_single(8'd1, 1'b0, "single");
      test_single(8'd0, 1'b0, "ntile0");
      test_multi_tile();
      test_err_drain();
      test_reset_mid();
      test_maclat_sweep();
      test_max_tiles();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/gobou_ctrl_mac_pipe.md
GOBOU_CTRL_MAC_PIPE -- requirements
Module: gobou_ctrl_mac_pipe

Interface
REQ-001 SHALL have parameter MACLAT, default 2: cycles from an accepted in_ctrl beat to its accumulator write. Legal range 1..8.
REQ-002 SHALL have parameter TILEWD, default 8: width of the tile-count input.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state is clocked on its rising edge.
REQ-004 SHALL have port xrst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port in_ctrl, ctrl_bus.slave, start/valid/stop 1 bit each: input stream control.
REQ-006 SHALL have port out_ctrl, ctrl_bus.master, start/valid/stop 1 bit each: output stream control.
REQ-007 SHALL have port n_tile, input, TILEWD bits: number of input segments summed per output; 0 is treated as 1.
REQ-008 SHALL have port mac_oe, output, 1 bit: MAC result output enable.
REQ-009 SHALL have port accum_we, output, 1 bit: accumulator write enable.
REQ-010 SHALL have port accum_rst, output, 1 bit: accumulator clear.
REQ-011 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-012 SHALL have port err, output, 1 bit: sticky protocol-error flag.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DRAIN, EMIT.
REQ-014 SHALL move IDLE->RUN on in_ctrl.start, latching n_eff = max(n_tile,1) and clearing the tile counter.
REQ-015 SHALL treat each in_ctrl.stop in RUN as a segment end and increment the tile counter; the stop cycle is never a data beat.
REQ-016 SHALL move RUN->DRAIN on the stop where the tile counter equals n_eff-1; that stop is tagged "last".
REQ-017 SHALL pass accepted valid, stop and last through a MACLAT-deep register delay line; in_ctrl is accepted only in RUN.
REQ-018 SHALL drive accum_we = delayed valid AND NOT delayed stop.
REQ-019 SHALL drive mac_oe = delayed stop AND delayed last, i.e. asserted exactly MACLAT cycles after the last stop.
REQ-020 SHALL make non-last stops produce no mac_oe, accum_rst or out_ctrl activity, so the accumulator carries across tiles.
REQ-021 SHALL move DRAIN->EMIT in the cycle after mac_oe, and EMIT->IDLE after one cycle.
REQ-022 SHALL assert out_ctrl.start in the mac_oe cycle, and assert accum_rst, out_ctrl.valid and out_ctrl.stop in the cycle after mac_oe (the EMIT cycle).
REQ-023 SHALL ignore in_ctrl.start while in RUN (segment boundary marker only).
REQ-024 SHALL set err and discard the start when in_ctrl.start arrives in DRAIN or EMIT; err is cleared only by reset.
REQ-025 SHALL ignore in_ctrl.valid and in_ctrl.stop in IDLE, DRAIN and EMIT.
REQ-026 SHALL wrap the tile counter modulo 2^TILEWD; n_tile = 2^TILEWD-1 SHALL be supported.
REQ-027 SHALL, with MACLAT=1 and n_tile=1, match single-stage timing: accum_we one cycle after the beat, mac_oe one cycle after stop.

Reset
REQ-028 SHALL, on xrst low, immediately force: state IDLE; delay line, tile counter and n_eff zero; all outputs 0 (mac_oe, accum_we, accum_rst, busy, err, out_ctrl.start/valid/stop).
REQ-029 SHALL abandon any in-flight tile on reset mid-operation; no partial mac_oe or out_ctrl pulse appears after release.
REQ-030 SHALL accept in_ctrl.start in the first clock edge after xrst rises.

Structure
REQ-031 SHALL place the FSM state enum and the MACLAT default in the shared gobou package; ctrl_bus and ctrl_reg are reused unchanged.
REQ-032 SHALL implement the delay line as sub-module gobou_ctrl_delay (parameters DEPTH, WIDTH, async-reset shift register), instantiated once, 3 bits wide.

Verification
REQ-033 SHALL cover: MACLAT=2, n_tile=1, start@0, valid@1..4, stop@5 -> accum_we@3..6; mac_oe and out start@7; accum_rst, out valid and out stop@8; busy high 1..8.
REQ-034 SHALL cover: n_tile=3, three segments of 2 beats each -> accum_we 6 pulses total; exactly one mac_oe, MACLAT after the 3rd stop; no accum_rst between tiles.
REQ-035 SHALL cover: n_tile=0 -> identical to n_tile=1.
REQ-036 SHALL cover: start during DRAIN -> err=1 and stays high; FSM returns to IDLE normally; the next start after IDLE works.
REQ-037 SHALL cover: xrst pulsed low during RUN of a 2-tile job -> all outputs 0 immediately; no mac_oe afterwards; a fresh job completes correctly.
REQ-038 SHALL cover: MACLAT=1 and MACLAT=8 sweeps -> mac_oe-to-stop distance equals MACLAT.
